// File: rtl/vx_tensor_writeback_pkg.sv
// Shared tensor-unit definitions: tile geometry, element width, the D tile
// type and the writeback FSM state encoding.
package vx_tensor_writeback_pkg;

    localparam int TENSOR_TILE_DIM   = 4;
    localparam int TENSOR_TILE_ELEMS = TENSOR_TILE_DIM * TENSOR_TILE_DIM;
    localparam int TENSOR_ELEM_W     = 32;

    typedef logic [TENSOR_TILE_DIM-1:0][TENSOR_TILE_DIM-1:0][TENSOR_ELEM_W-1:0] tensor_tile_t;

    typedef enum logic {
        WB_IDLE  = 1'b0,
        WB_DRAIN = 1'b1
    } wb_state_e;

    // Width of a beat index; a one-beat tile still gets a 1-bit index.
    function automatic int beat_idx_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/vx_tensor_wb_perf.sv
// Performance counters for the tensor writeback block: accepted tiles and
// stalled beat cycles. Both wrap modulo 2^32 and show an event one cycle later.
module vx_tensor_wb_perf (
    input  logic        clk,
    input  logic        reset,
    input  logic        tile_accept,
    input  logic        beat_stall,
    output logic [31:0] perf_tiles,
    output logic [31:0] perf_stalls
);

    // Free-running event counters, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_tiles  <= '0;
            perf_stalls <= '0;
        end else begin
            if (tile_accept) perf_tiles  <= perf_tiles + 32'd1;
            if (beat_stall)  perf_stalls <= perf_stalls + 32'd1;
        end
    end

endmodule

// File: rtl/vx_tensor_writeback.sv
// Tensor DPU result writeback: latches one 4x4 FP32 D tile per handshake and
// drains it as NUM_LANES-wide beats toward commit. A new tile can be taken on
// the same cycle the last beat fires, so back-to-back tiles leave no bubble.
// Optional build macro: TENSOR_WB_PERF_EN adds perf_tiles / perf_stalls ports.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   WB_IDLE  | holding register empty, ready_in high, no beat presented
//   WB_DRAIN | beat cnt_q of the held tile presented on valid_out
module vx_tensor_writeback
    import vx_tensor_writeback_pkg::*;
#(
    parameter  int NUM_LANES = 4,
    parameter  int NW_WIDTH  = 4,
    localparam int NUM_BEATS = TENSOR_TILE_ELEMS / NUM_LANES,
    localparam int BIDX_W    = beat_idx_width(NUM_BEATS)
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    valid_in,
    output logic                                    ready_in,
    input  logic [TENSOR_TILE_DIM-1:0][TENSOR_TILE_DIM-1:0][TENSOR_ELEM_W-1:0] D_tile,
    input  logic [NW_WIDTH-1:0]                     D_wid,
    output logic                                    valid_out,
    input  logic                                    ready_out,
    output logic [NUM_LANES-1:0][TENSOR_ELEM_W-1:0] data_out,
    output logic [NW_WIDTH-1:0]                     wid_out,
    output logic [BIDX_W-1:0]                       beat_idx,
    output logic                                    last_out
`ifdef TENSOR_WB_PERF_EN
    ,
    output logic [31:0]                             perf_tiles,
    output logic [31:0]                             perf_stalls
`endif
);

    localparam logic [BIDX_W-1:0] LAST_BEAT = BIDX_W'(NUM_BEATS - 1);

    wb_state_e                                   state_q;
    wb_state_e                                   state_d;
    logic [BIDX_W-1:0]                           cnt_q;
    tensor_tile_t                                tile_q;
    logic [NW_WIDTH-1:0]                         wid_q;
    logic [TENSOR_TILE_ELEMS*TENSOR_ELEM_W-1:0]  tile_flat;
    logic                                        fire;
    logic                                        last_fire;
    logic                                        accept;

    assign valid_out = (state_q == WB_DRAIN);
    assign fire      = valid_out && ready_out;
    assign last_fire = fire && (cnt_q == LAST_BEAT);
    // The slot frees up in the same cycle the final beat leaves.
    assign ready_in  = (state_q == WB_IDLE) || last_fire;
    assign accept    = valid_in && ready_in;

    assign wid_out   = wid_q;
    assign beat_idx  = cnt_q;
    assign last_out  = valid_out && (cnt_q == LAST_BEAT);
    assign tile_flat = tile_q;

    // Next-state logic: enter DRAIN on a tile, leave only on an unrefilled last fire.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WB_IDLE: begin
                if (valid_in) state_d = WB_DRAIN;
            end
            WB_DRAIN: begin
                if (last_fire && !valid_in) state_d = WB_IDLE;
            end
            default: state_d = WB_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= WB_IDLE;
        else       state_q <= state_d;
    end

    // Holding register and beat counter; the counter only wraps via a last fire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tile_q <= '0;
            wid_q  <= '0;
            cnt_q  <= '0;
        end else begin
            if (accept) begin
                tile_q <= D_tile;
                wid_q  <= D_wid;
            end
            if (accept || last_fire) cnt_q <= '0;
            else if (fire)           cnt_q <= cnt_q + 1'b1;
        end
    end

    // Beat mux: lane j of beat k carries flattened element k*NUM_LANES+j.
    always_comb begin
        data_out = '0;
        for (int j = 0; j < NUM_LANES; j++) begin
            data_out[j] = tile_flat[(int'(cnt_q) * NUM_LANES + j) * TENSOR_ELEM_W +: TENSOR_ELEM_W];
        end
    end

`ifdef TENSOR_WB_PERF_EN
    vx_tensor_wb_perf u_perf (
        .clk         (clk),
        .reset       (reset),
        .tile_accept (accept),
        .beat_stall  (valid_out && !ready_out),
        .perf_tiles  (perf_tiles),
        .perf_stalls (perf_stalls)
    );
`endif

endmodule

// File: tb/tb_vx_tensor_writeback.sv
// Bench for vx_tensor_writeback: a 4-lane instance driven by directed and
// random traffic against a queue-of-beats reference, plus a 16-lane instance.
module tb_vx_tensor_writeback;
    import vx_tensor_writeback_pkg::*;

    localparam int NL = 4;
    localparam int NB = 16 / NL;
    localparam int NW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic                 valid_in, ready_in, valid_out, ready_out, last_out;
    tensor_tile_t         d_tile;
    logic [NW-1:0]        d_wid, wid_out;
    logic [NL-1:0][31:0]  data_out;
    logic [1:0]           beat_idx;

    logic                 w_valid_in, w_ready_in, w_valid_out, w_ready_out, w_last_out;
    tensor_tile_t         w_tile;
    logic [NW-1:0]        w_wid, w_wid_out;
    logic [15:0][31:0]    w_data_out;
    logic                 w_beat_idx;
`ifdef TENSOR_WB_PERF_EN
    logic [31:0] perf_tiles, perf_stalls, w_perf_tiles, w_perf_stalls;
`endif

    vx_tensor_writeback #(.NUM_LANES(NL), .NW_WIDTH(NW)) u_dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
        .D_tile(d_tile), .D_wid(d_wid), .valid_out(valid_out), .ready_out(ready_out),
        .data_out(data_out), .wid_out(wid_out), .beat_idx(beat_idx), .last_out(last_out)
`ifdef TENSOR_WB_PERF_EN
        , .perf_tiles(perf_tiles), .perf_stalls(perf_stalls)
`endif
    );

    vx_tensor_writeback #(.NUM_LANES(16), .NW_WIDTH(NW)) u_wide (
        .clk(clk), .reset(reset), .valid_in(w_valid_in), .ready_in(w_ready_in),
        .D_tile(w_tile), .D_wid(w_wid), .valid_out(w_valid_out), .ready_out(w_ready_out),
        .data_out(w_data_out), .wid_out(w_wid_out), .beat_idx(w_beat_idx), .last_out(w_last_out)
`ifdef TENSOR_WB_PERF_EN
        , .perf_tiles(w_perf_tiles), .perf_stalls(w_perf_stalls)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: the beats still owed to commit, oldest first.
    typedef struct {
        logic [NL*32-1:0] data;
        logic [NW-1:0]    wid;
        logic [1:0]       idx;
    } beat_t;

    beat_t q[$];
    int    m_tiles  = 0;
    int    m_stalls = 0;
    bit    accepted = 0;

    function automatic tensor_tile_t rand_tile();
        tensor_tile_t t;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r][c] = $urandom;
        return t;
    endfunction

    function automatic void push_tile(input tensor_tile_t t, input logic [NW-1:0] w);
        beat_t b;
        for (int k = 0; k < NB; k++) begin
            b.data = '0;
            for (int j = 0; j < NL; j++) begin
                int e;
                e = k * NL + j;
                b.data[j*32 +: 32] = t[e/4][e%4];
            end
            b.wid = w;
            b.idx = 2'(k);
            q.push_back(b);
        end
    endfunction

    // One clock of the narrow instance: compare on the falling edge, then advance the model.
    task automatic cycle();
        bit m_ready, fire, acc;
        @(negedge clk);
        m_ready = (q.size() == 0) || (q.size() == 1 && ready_out);
        check_val("ready_in", ready_in, m_ready);
        check_val("valid_out", valid_out, q.size() != 0);
        if (q.size() != 0) begin
            check_val("data_out", data_out, q[0].data);
            check_val("wid_out", wid_out, q[0].wid);
            check_val("beat_idx", beat_idx, q[0].idx);
            check_val("last_out", last_out, q.size() == 1);
        end else begin
            check_val("last_out_idle", last_out, 1'b0);
        end
`ifdef TENSOR_WB_PERF_EN
        check_val("perf_tiles", perf_tiles, 32'(m_tiles));
        check_val("perf_stalls", perf_stalls, 32'(m_stalls));
`endif
        fire = (q.size() != 0) && ready_out;
        acc  = valid_in && m_ready;
        if (q.size() != 0 && !ready_out) m_stalls++;
        if (fire) void'(q.pop_front());
        if (acc) begin
            push_tile(d_tile, d_wid);
            m_tiles++;
        end
        accepted = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ready_in"}, ready_in, 1'b1);
        check_val({tag, "_valid_out"}, valid_out, 1'b0);
        check_val({tag, "_data_out"}, data_out, '0);
        check_val({tag, "_wid_out"}, wid_out, '0);
        check_val({tag, "_beat_idx"}, beat_idx, '0);
        check_val({tag, "_last_out"}, last_out, 1'b0);
        check_val({tag, "_w_valid_out"}, w_valid_out, 1'b0);
        check_val({tag, "_w_ready_in"}, w_ready_in, 1'b1);
`ifdef TENSOR_WB_PERF_EN
        check_val({tag, "_perf_tiles"}, perf_tiles, '0);
        check_val({tag, "_perf_stalls"}, perf_stalls, '0);
`endif
    endtask

    task automatic wait_accept(input string tag);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!accepted && n < 20);
        check_val({tag, "_accept_timeout"}, accepted, 1'b1);
    endtask

    initial begin
        tensor_tile_t  pat;
        tensor_tile_t  wt [3];
        logic [511:0]  exp_flat;

        reset = 1'b1;
        valid_in = 1'b0; ready_out = 1'b1; d_tile = '0; d_wid = '0;
        w_valid_in = 1'b0; w_ready_out = 1'b1; w_tile = '0; w_wid = '0;
        #1;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Single tile, no back-pressure.
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                pat[r][c] = 32'h100 * r + c;
        d_tile = pat; d_wid = 4'd3; valid_in = 1'b1;
        cycle();
        valid_in = 1'b0;
        check_val("first_beat_const", data_out, 128'h00000003_00000002_00000001_00000000);
        repeat (6) cycle();

        // Back-to-back tiles with valid_in held high.
        d_tile = rand_tile(); d_wid = 4'd1; valid_in = 1'b1;
        wait_accept("b2b_t1");
        d_tile = rand_tile(); d_wid = 4'd2;
        wait_accept("b2b_t2");
        valid_in = 1'b0;
        repeat (6) cycle();

        // Back-pressure: beat 1 stalled for three cycles.
        d_tile = rand_tile(); d_wid = 4'd5; valid_in = 1'b1;
        cycle();
        valid_in = 1'b0;
        cycle();
        ready_out = 1'b0;
        repeat (3) cycle();
        ready_out = 1'b1;
        repeat (5) cycle();

        // Reset in the middle of a drain.
        d_tile = rand_tile(); d_wid = 4'd7; valid_in = 1'b1;
        cycle();
        valid_in = 1'b0;
        cycle();
        cycle();
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        q.delete();
        m_tiles = 0;
        m_stalls = 0;
        @(posedge clk);
        #1 reset = 1'b0;
        cycle();
        d_tile = rand_tile(); d_wid = 4'd9; valid_in = 1'b1;
        cycle();
        valid_in = 1'b0;
        repeat (5) cycle();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            if (!valid_in || accepted) begin
                valid_in = ($urandom_range(0, 2) != 0);
                d_tile   = rand_tile();
                d_wid    = NW'($urandom);
            end
            ready_out = ($urandom_range(0, 3) != 0);
            cycle();
        end
        valid_in = 1'b0;
        ready_out = 1'b1;
        repeat (6) cycle();

        // Wide configuration: one beat per tile, tiles back to back.
        for (int t = 0; t < 3; t++) wt[t] = rand_tile();
        w_ready_out = 1'b1;
        for (int t = 0; t < 3; t++) begin
            w_tile = wt[t]; w_wid = NW'(t + 1); w_valid_in = 1'b1;
            @(posedge clk);
            #1;
            for (int e = 0; e < 16; e++) exp_flat[e*32 +: 32] = wt[t][e/4][e%4];
            check_val("w_valid_out", w_valid_out, 1'b1);
            check_val("w_last_out", w_last_out, 1'b1);
            check_val("w_beat_idx", w_beat_idx, 1'b0);
            check_val("w_data_out", w_data_out, exp_flat);
            check_val("w_wid_out", w_wid_out, NW'(t + 1));
            check_val("w_ready_in", w_ready_in, 1'b1);
        end
        w_valid_in = 1'b0;
        @(posedge clk);
        #1;
        check_val("w_idle_valid_out", w_valid_out, 1'b0);
        check_val("w_idle_last_out", w_last_out, 1'b0);
`ifdef TENSOR_WB_PERF_EN
        check_val("w_perf_tiles", w_perf_tiles, 32'd3);
        check_val("w_perf_stalls", w_perf_stalls, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
